mem_stage_unit: RTL and testbench

//  MEM stage of the RV32I pipeline. Consumes the rv32i_control_word, ALU result and rs2 data from the EX/MEM register.

---
 rtl/mem_stage_unit_pkg.sv | 64 ++++++
 rtl/mem_stage_unit_if.sv | 20 ++
 rtl/mem_stage_unit_load_align.sv | 24 ++
 rtl/mem_stage_unit.sv | 117 +++++++++++
 tb/tb_mem_stage_unit.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_unit_pkg.sv
// Shared RV32I types for the MEM stage: control word, funct3 encodings,
// FSM state and the store lane-formatting helpers.
package mem_stage_unit_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    typedef enum logic {MEM_IDLE, MEM_BUSY} mem_state_t;

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} access_size_t;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic       mem_read;
        logic       mem_write;
        logic [3:0] mem_byte_enable;
        logic       load_regfile;
        logic [4:0] rd;
    } rv32i_control_word;

    // funct3[1:0] fixes the access width; undefined encodings fall to word
    function automatic access_size_t access_size(input logic [2:0] funct3);
        access_size_t sz;
        case (funct3[1:0])
            2'b00:   sz = SZ_BYTE;
            2'b01:   sz = SZ_HALF;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (access_size(funct3))
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: be = 4'b0011 << {addr_lo[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] rs2);
        logic [31:0] wd;
        case (access_size(funct3))
            SZ_BYTE: wd = {4{rs2[7:0]}};
            SZ_HALF: wd = {2{rs2[15:0]}};
            default: wd = rs2;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/mem_stage_unit_if.sv
// Data-memory port: level request held until a one-cycle response pulse.
interface mem_stage_unit_if;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [3:0]  dmem_byte_enable;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;

    modport master (
        output dmem_read, dmem_write, dmem_address, dmem_byte_enable, dmem_wdata,
        input  dmem_rdata, dmem_resp
    );

    modport slave (
        input  dmem_read, dmem_write, dmem_address, dmem_byte_enable, dmem_wdata,
        output dmem_rdata, dmem_resp
    );
endinterface

// File: rtl/mem_stage_unit_load_align.sv
// Load-data alignment and sign/zero extension from the addressed byte lane.
module mem_load_align
    import mem_stage_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        case (load_funct3_t'(funct3))
            LB:      result = {{24{shifted[7]}}, shifted[7:0]};
            LBU:     result = {24'h0, shifted[7:0]};
            LH:      result = {{16{shifted[15]}}, shifted[15:0]};
            LHU:     result = {16'h0, shifted[15:0]};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_unit.sv
// RV32I MEM stage: issues one data-memory access at a time, stalls upstream
// until the response, then loads the MEM/WB register.
module mem_stage_unit
    import mem_stage_unit_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_in,
    input  rv32i_control_word    ctrl_in,
    input  logic [31:0]          alu_in,
    input  logic [31:0]          rs2_in,
    mem_stage_unit_if.master     dmem,
    output logic                 stall_out,
    output logic                 misalign_out,
    output logic                 wb_valid,
    output rv32i_control_word    wb_ctrl,
    output logic [31:0]          wb_alu,
    output logic [31:0]          wb_load,
    output logic [CNT_W-1:0]     stall_cycles
);

    mem_state_t        state;
    rv32i_control_word lat_ctrl;
    logic [31:0]       lat_alu;
    logic [1:0]        lat_lo;
    logic [31:0]       load_result;

    logic              is_mem;
    logic              misaligned;
    logic              start;
    access_size_t      size;
    rv32i_control_word idle_ctrl;

    always_comb begin
        is_mem     = valid_in && (ctrl_in.mem_read || ctrl_in.mem_write);
        size       = access_size(ctrl_in.funct3);
        misaligned = ALIGN_CHECK &&
                     (((size == SZ_HALF) && alu_in[0]) ||
                      ((size == SZ_WORD) && (alu_in[1:0] != 2'b00)));
        start        = (state == MEM_IDLE) && is_mem && !misaligned;
        misalign_out = (state == MEM_IDLE) && is_mem && misaligned;
        stall_out    = start || ((state == MEM_BUSY) && !dmem.dmem_resp);
        // A squashed access still retires, but must not write the register file
        idle_ctrl = ctrl_in;
        if (misalign_out)
            idle_ctrl.load_regfile = 1'b0;
    end

    mem_load_align u_align (
        .rdata   (dmem.dmem_rdata),
        .addr_lo (lat_lo),
        .funct3  (lat_ctrl.funct3),
        .result  (load_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                 <= MEM_IDLE;
            dmem.dmem_read        <= 1'b0;
            dmem.dmem_write       <= 1'b0;
            dmem.dmem_address     <= '0;
            dmem.dmem_byte_enable <= '0;
            dmem.dmem_wdata       <= '0;
            lat_ctrl              <= '0;
            lat_alu               <= '0;
            lat_lo                <= '0;
            wb_valid              <= 1'b0;
            wb_ctrl               <= '0;
            wb_alu                <= '0;
            wb_load               <= '0;
            stall_cycles          <= '0;
        end else begin
            if (stall_out && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);

            unique case (state)
                MEM_IDLE: begin
                    if (start) begin
                        state                 <= MEM_BUSY;
                        dmem.dmem_read        <= ctrl_in.mem_read;
                        dmem.dmem_write       <= ctrl_in.mem_write;
                        dmem.dmem_address     <= {alu_in[31:2], 2'b00};
                        dmem.dmem_byte_enable <= store_be(ctrl_in.funct3, alu_in[1:0]);
                        dmem.dmem_wdata       <= store_data(ctrl_in.funct3, rs2_in);
                        lat_ctrl              <= ctrl_in;
                        lat_alu               <= alu_in;
                        lat_lo                <= alu_in[1:0];
                        wb_valid              <= 1'b0;
                    end else begin
                        wb_valid <= valid_in;
                        wb_ctrl  <= idle_ctrl;
                        wb_alu   <= alu_in;
                        wb_load  <= '0;
                    end
                end
                MEM_BUSY: begin
                    if (dmem.dmem_resp) begin
                        state           <= MEM_IDLE;
                        dmem.dmem_read  <= 1'b0;
                        dmem.dmem_write <= 1'b0;
                        wb_valid        <= 1'b1;
                        wb_ctrl         <= lat_ctrl;
                        wb_alu          <= lat_alu;
                        wb_load         <= load_result;
                    end else begin
                        wb_valid <= 1'b0;
                    end
                end
                default: state <= MEM_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed plus randomized checks of mem_stage_unit against a lane-level model.
module tb_mem_stage_unit;
    import mem_stage_unit_pkg::*;

    localparam int CW = $bits(rv32i_control_word);

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              valid_in = 1'b0;
    rv32i_control_word ctrl_in = '0;
    logic [31:0]       alu_in = '0;
    logic [31:0]       rs2_in = '0;

    logic              stall_out, misalign_out, wb_valid;
    rv32i_control_word wb_ctrl;
    logic [31:0]       wb_alu, wb_load, stall_cycles;

    logic              s_stall, s_misalign, s_wb_valid;
    rv32i_control_word s_wb_ctrl;
    logic [31:0]       s_wb_alu, s_wb_load;
    logic [2:0]        s_stall_cycles;

    mem_stage_unit_if dmem ();
    mem_stage_unit_if dmem_s ();

    assign dmem_s.dmem_rdata = dmem.dmem_rdata;
    assign dmem_s.dmem_resp  = dmem.dmem_resp;

    always #5 clk = ~clk;

    mem_stage_unit #(.CNT_W(32), .ALIGN_CHECK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ctrl_in(ctrl_in),
        .alu_in(alu_in), .rs2_in(rs2_in), .dmem(dmem.master),
        .stall_out(stall_out), .misalign_out(misalign_out), .wb_valid(wb_valid),
        .wb_ctrl(wb_ctrl), .wb_alu(wb_alu), .wb_load(wb_load), .stall_cycles(stall_cycles)
    );

    mem_stage_unit #(.CNT_W(3), .ALIGN_CHECK(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ctrl_in(ctrl_in),
        .alu_in(alu_in), .rs2_in(rs2_in), .dmem(dmem_s.master),
        .stall_out(s_stall), .misalign_out(s_misalign), .wb_valid(s_wb_valid),
        .wb_ctrl(s_wb_ctrl), .wb_alu(s_wb_alu), .wb_load(s_wb_load), .stall_cycles(s_stall_cycles)
    );

    int          n_assert = 0;
    int          n_fail = 0;
    int unsigned stall_model = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model: lane arithmetic from access width and address
    function automatic int nbytes(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic bit is_misaligned(input logic [2:0] f3, input logic [31:0] a);
        return (int'(a[1:0]) % nbytes(f3)) != 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
        int nb = nbytes(f3);
        int st = (int'(a[1:0]) / nb) * nb;
        logic [3:0] be;
        for (int i = 0; i < 4; i++) be[i] = (i >= st) && (i < st + nb);
        return be;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        int nb = nbytes(f3);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = rs2[8*(i % nb) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rdata);
        int nb = nbytes(f3);
        longint unsigned d, m, v;
        if (nb == 4) return rdata;
        d = 64'(rdata) >> (8 * int'(a[1:0]));
        m = 64'd1 << (8 * nb);
        v = d % m;
        if ((f3 == 3'd0 || f3 == 3'd1) && v >= m / 2) v = v + 64'h1_0000_0000 - m;
        return v[31:0];
    endfunction

    function automatic rv32i_control_word mk_ctrl(input int kind, input logic [2:0] f3);
        rv32i_control_word c;
        c.opcode          = (kind == 0) ? 7'b0110011 : (kind == 1) ? 7'b0000011 : 7'b0100011;
        c.funct3          = f3;
        c.mem_read        = (kind == 1);
        c.mem_write       = (kind == 2);
        c.mem_byte_enable = 4'($urandom);
        c.load_regfile    = (kind != 2);
        c.rd              = 5'($urandom);
        return c;
    endfunction

    function automatic int unsigned sat7(input int unsigned x);
        return (x > 7) ? 7 : x;
    endfunction

    task automatic op_alu(input bit v, input logic [31:0] a);
        rv32i_control_word c;
        c = mk_ctrl(0, 3'($urandom));
        valid_in = v; ctrl_in = c; alu_in = a; rs2_in = $urandom;
        @(negedge clk);
        chk("alu stall_out", stall_out, 0);
        tick;
        chk("alu wb_valid", wb_valid, v);
        chk("alu wb_alu", wb_alu, a);
        chk("alu wb_load", wb_load, 0);
        chk("alu wb_ctrl", {{(32-CW){1'b0}}, wb_ctrl}, {{(32-CW){1'b0}}, c});
        valid_in = 0;
    endtask

    task automatic op_mem(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rs2, input logic [31:0] rdata, input int wait_n,
                          output logic [3:0] be_seen, output logic [31:0] wd_seen);
        rv32i_control_word c, cm;
        c = mk_ctrl(st ? 2 : 1, f3);
        valid_in = 1; ctrl_in = c; alu_in = a; rs2_in = rs2;
        be_seen = 'x; wd_seen = 'x;
        @(negedge clk);
        if (is_misaligned(f3, a)) begin
            chk("mis misalign_out", misalign_out, 1);
            chk("mis stall_out", stall_out, 0);
            tick;
            cm = c;
            cm.load_regfile = 1'b0;
            chk("mis dmem_req", {dmem.dmem_read, dmem.dmem_write}, 0);
            chk("mis wb_valid", wb_valid, 1);
            chk("mis wb_ctrl", {{(32-CW){1'b0}}, wb_ctrl}, {{(32-CW){1'b0}}, cm});
            chk("mis wb_load", wb_load, 0);
            valid_in = 0;
            return;
        end
        chk("mem idle stall", stall_out, 1);
        chk("mem idle misalign", misalign_out, 0);
        chk("mem idle no req", {dmem.dmem_read, dmem.dmem_write}, 0);
        stall_model++;
        tick;
        for (int k = 0; k <= wait_n; k++) begin
            dmem.dmem_resp  = (k == wait_n);
            dmem.dmem_rdata = (k == wait_n) ? rdata : $urandom;
            @(negedge clk);
            if (k == 0) begin
                chk("bus read", dmem.dmem_read, !st);
                chk("bus write", dmem.dmem_write, st);
                chk("bus address", dmem.dmem_address, {a[31:2], 2'b00});
                be_seen = dmem.dmem_byte_enable;
                wd_seen = dmem.dmem_wdata;
                if (st) begin
                    chk("bus be", dmem.dmem_byte_enable, exp_be(f3, a));
                    chk("bus wdata", dmem.dmem_wdata, exp_wdata(f3, rs2));
                end
            end
            chk("busy stall", stall_out, k != wait_n);
            if (k != wait_n) stall_model++;
            tick;
            dmem.dmem_resp = 0;
        end
        valid_in = 0;
        chk("resp req dropped", {dmem.dmem_read, dmem.dmem_write}, 0);
        chk("resp wb_valid", wb_valid, 1);
        chk("resp wb_ctrl", {{(32-CW){1'b0}}, wb_ctrl}, {{(32-CW){1'b0}}, c});
        chk("resp wb_alu", wb_alu, a);
        chk("resp wb_load", wb_load, exp_load(f3, a, rdata));
        chk("stall_cycles", stall_cycles, stall_model);
        chk("stall_cycles sat", s_stall_cycles, sat7(stall_model));
    endtask

    logic [3:0]  be_s;
    logic [31:0] wd_s;

    initial begin
        dmem.dmem_resp  = 0;
        dmem.dmem_rdata = '0;

        // Reset state
        #1 rst_n = 0;
        #3;
        chk("rst dmem_read", dmem.dmem_read, 0);
        chk("rst dmem_write", dmem.dmem_write, 0);
        chk("rst dmem_address", dmem.dmem_address, 0);
        chk("rst dmem_be", dmem.dmem_byte_enable, 0);
        chk("rst stall_out", stall_out, 0);
        chk("rst wb_valid", wb_valid, 0);
        chk("rst wb_ctrl", {{(32-CW){1'b0}}, wb_ctrl}, 0);
        chk("rst stall_cycles", stall_cycles, 0);
        @(negedge clk);
        rst_n = 1;
        tick;

        // sw, response after three waiting cycles
        op_mem(1, 3'(SW), 32'h100, 32'hDEADBEEF, 32'h0, 3, be_s, wd_s);
        chk("t1 be", be_s, 4'b1111);
        chk("t1 wdata", wd_s, 32'hDEADBEEF);
        chk("t1 stall_cycles", stall_cycles, 4);

        // Loads from the upper lanes
        op_mem(0, 3'(LB), 32'h103, 32'h0, 32'h80FF_0000, 1, be_s, wd_s);
        chk("t2 lb", wb_load, 32'hFFFFFF80);
        op_mem(0, 3'(LBU), 32'h103, 32'h0, 32'h80FF_0000, 0, be_s, wd_s);
        chk("t2 lbu", wb_load, 32'h00000080);
        op_mem(0, 3'(LHU), 32'h102, 32'h0, 32'h80FF_0000, 2, be_s, wd_s);
        chk("t2 lhu", wb_load, 32'h000080FF);

        // Sub-word stores
        op_mem(1, 3'(SH), 32'h102, 32'h1234ABCD, 32'h0, 0, be_s, wd_s);
        chk("t3 sh be", be_s, 4'b1100);
        chk("t3 sh wdata", wd_s, 32'hABCDABCD);
        op_mem(1, 3'(SB), 32'h101, 32'h1234ABCD, 32'h0, 1, be_s, wd_s);
        chk("t3 sb be", be_s, 4'b0010);
        chk("t3 sb wdata", wd_s, 32'hCDCDCDCD);

        // Misaligned word load is squashed
        op_mem(0, 3'(LW), 32'h101, 32'h0, 32'h0, 0, be_s, wd_s);
        chk("t4 load_regfile", wb_ctrl.load_regfile, 0);

        // Reset while an access is outstanding
        valid_in = 1; ctrl_in = mk_ctrl(1, 3'(LW)); alu_in = 32'h200;
        tick;
        tick;
        chk("t5 busy read", dmem.dmem_read, 1);
        #2 rst_n = 0;
        valid_in = 0;
        #1;
        chk("t5 read dropped", dmem.dmem_read, 0);
        chk("t5 stall_out", stall_out, 0);
        chk("t5 stall_cycles", stall_cycles, 0);
        stall_model = 0;
        @(negedge clk);
        rst_n = 1;
        tick;
        dmem.dmem_resp = 1; dmem.dmem_rdata = $urandom;
        @(negedge clk);
        chk("t5 late resp stall", stall_out, 0);
        tick;
        dmem.dmem_resp = 0;
        chk("t5 late resp wb_valid", wb_valid, 0);
        chk("t5 late resp read", dmem.dmem_read, 0);

        // add, lw with immediate response, add
        op_alu(1, 32'h11);
        op_mem(0, 3'(LW), 32'h204, 32'h0, 32'hCAFEF00D, 0, be_s, wd_s);
        op_alu(1, 32'h22);
        chk("t6 one stall", stall_cycles, 1);

        // Randomized mix
        for (int n = 0; n < 80; n++) begin
            int kind = $urandom_range(0, 2);
            logic [31:0] a = 32'h1000 + 32'($urandom_range(0, 255));
            logic [2:0] f3;
            if (kind == 0) begin
                op_alu(1'($urandom), a);
            end else if (kind == 1) begin
                case ($urandom_range(0, 5))
                    0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2;
                    3: f3 = 3'd4; 4: f3 = 3'd5; default: f3 = 3'd6;
                endcase
                op_mem(0, f3, a, 32'h0, $urandom, $urandom_range(0, 3), be_s, wd_s);
            end else begin
                f3 = 3'($urandom_range(0, 2));
                op_mem(1, f3, a, $urandom, 32'h0, $urandom_range(0, 3), be_s, wd_s);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
